// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch path: data/address widths, instruction
// field bounds, opcode constants and the fetch sequencer state encoding.
package cpu_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int IMM_W   = 12;

  localparam logic [OPC_MSB-OPC_LSB:0] OP_JMP = 4'hC;
  localparam logic [OPC_MSB-OPC_LSB:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_CLR,
    ST_SETTLE,
    ST_REQ,
    ST_PRESENT,
    ST_ADVANCE,
    ST_HALT
  } fetch_state_e;

  function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [DATA_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/pc_settle_timer.sv
// Counts 0..PC_SETTLE-1 while run is high and parks on the final count;
// load (or rst) returns it to 0. done flags the final count.
module pc_settle_timer #(
  parameter int PC_SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic done
);

  localparam int CNT_W = (PC_SETTLE > 1) ? $clog2(PC_SETTLE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PC_SETTLE - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (run && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: samples the PC after it settles, reads the ROM
// (req/ack), presents the IR to the decoder (valid/ready) and steers the PC.
//
// Handshakes: rom_req stays high with rom_addr stable until the cycle rom_ack
// is seen at an edge; ir_valid stays high with ir stable until ir_ready is seen
// at an edge. Either side may respond in the very first cycle of the request.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_load,
  output logic              pc_inc,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  fetch_state_e state, state_next;
  logic         settle_done;
  logic         is_jmp;
  logic         is_hlt;

  assign is_jmp = (opcode_of(ir) == OP_JMP);
  assign is_hlt = (opcode_of(ir) == OP_HLT);

  pc_settle_timer #(.PC_SETTLE(PC_SETTLE)) u_settle (
    .clk  (clk),
    .rst  (rst),
    .load (state != ST_SETTLE),
    .run  (state == ST_SETTLE),
    .done (settle_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    rom_req    = 1'b0;
    ir_valid   = 1'b0;
    halted     = 1'b0;
    case (state)
      ST_CLR: begin
        pc_load    = 1'b1;
        pc_inc     = 1'b1;
        state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_done && run) state_next = ST_REQ;
      end
      ST_REQ: begin
        rom_req = 1'b1;
        if (rom_ack) state_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        ir_valid = 1'b1;
        if (ir_ready) state_next = is_hlt ? ST_HALT : ST_ADVANCE;
      end
      ST_ADVANCE: begin
        pc_load    = is_jmp;
        pc_inc     = !is_jmp;
        state_next = ST_SETTLE;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: state_next = ST_CLR;
    endcase
  end

  // Jump target keeps the current 4K page of the fetch address.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr    <= '0;
      jump_addr   <= '0;
      ir          <= '0;
      fetch_count <= '0;
    end else begin
      if (state == ST_SETTLE && settle_done && run) begin
        rom_addr <= pc_addr;
      end
      if (state == ST_REQ && rom_ack) begin
        ir <= rom_data;
      end
      if (state == ST_PRESENT && ir_ready) begin
        fetch_count <= fetch_count + 16'd1;
        if (!is_hlt) jump_addr <= {rom_addr[ADDR_W-1:IMM_W], ir[IMM_W-1:0]};
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small PC model closes the loop, ROM
// responses are driven per transaction with hand-computed expectations.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b1;
  logic [15:0] pc_addr = 16'h0;
  logic        pc_load, pc_inc;
  logic [15:0] jump_addr;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_ack = 1'b0;
  logic [15:0] rom_data = 16'h0;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready = 1'b1;
  logic        halted;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.PC_SETTLE(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .pc_addr     (pc_addr),
    .pc_load     (pc_load),
    .pc_inc      (pc_inc),
    .jump_addr   (jump_addr),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_ack     (rom_ack),
    .rom_data    (rom_data),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // Program counter model driven by the fetch unit's commands.
  always @(posedge clk) begin
    if (pc_load && pc_inc)  pc_addr <= 16'h0;
    else if (pc_load)       pc_addr <= jump_addr;
    else if (pc_inc)        pc_addr <= pc_addr + 16'd1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    check_eq("rst_pc_clr", {30'd0, pc_load, pc_inc}, 32'h3);
    check_eq("rst_req", rom_req, 0);
    check_eq("rst_valid", ir_valid, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_ir", ir, 0);
    check_eq("rst_count", fetch_count, 0);
    check_eq("rst_addr", rom_addr, 0);
    rst = 1'b0;
  endtask

  // Called in the first REQ cycle; ack follows after ack_delay idle cycles.
  task automatic fetch_one(input logic [15:0] word, input int ack_delay);
    logic [15:0] a;
    a = rom_addr;
    for (int i = 0; i < ack_delay; i++) begin
      step();
      check_eq("wait_req", rom_req, 1);
      check_eq("wait_addr", rom_addr, a);
      check_eq("wait_no_cmd", pc_load | pc_inc, 0);
    end
    rom_ack  = 1'b1;
    rom_data = word;
    step();
    rom_ack  = 1'b0;
    rom_data = 16'h0;
    check_eq("ir_load", ir, word);
    check_eq("ir_valid", ir_valid, 1);
  endtask

  // From ADVANCE: two SETTLE cycles, then REQ with the updated PC.
  task automatic to_req(input logic [15:0] exp_addr);
    step();
    check_eq("settle_no_cmd", pc_load | pc_inc, 0);
    step();
    check_eq("settle_no_req", rom_req, 0);
    step();
    check_eq("req_rise", rom_req, 1);
    check_eq("req_addr", rom_addr, exp_addr);
  endtask

  initial begin
    int act;

    // Reset, first fetch at address 0 with single-cycle ack.
    do_reset();
    check_eq("clr_cmd", {30'd0, pc_load, pc_inc}, 32'h3);
    step();
    check_eq("settle0_cmd", pc_load | pc_inc, 0);
    check_eq("settle0_req", rom_req, 0);
    step();
    check_eq("settle1_req", rom_req, 0);
    step();
    check_eq("first_req", rom_req, 1);
    check_eq("first_addr", rom_addr, 16'h0000);
    fetch_one(16'h1000, 0);
    step();
    check_eq("adv_inc", {30'd0, pc_load, pc_inc}, 32'h1);
    check_eq("count1", fetch_count, 1);
    to_req(16'h0001);

    // Absolute jump keeps page of rom_addr (0) -> 0x00A5.
    fetch_one(16'hC0A5, 0);
    step();
    check_eq("jmp_cmd", {30'd0, pc_load, pc_inc}, 32'h2);
    check_eq("jmp_addr", jump_addr, 16'h00A5);
    check_eq("count2", fetch_count, 2);
    to_req(16'h00A5);

    // Slow ROM: ack after 5 waiting cycles.
    fetch_one(16'h2000, 5);
    step();
    check_eq("slow_inc", {30'd0, pc_load, pc_inc}, 32'h1);
    check_eq("count3", fetch_count, 3);
    to_req(16'h00A6);

    // Halt with decoder stalled for 4 cycles.
    ir_ready = 1'b0;
    fetch_one(16'hF000, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq("stall_valid", ir_valid, 1);
      check_eq("stall_ir", ir, 16'hF000);
      check_eq("stall_count", fetch_count, 3);
      step();
    end
    ir_ready = 1'b1;
    step();
    check_eq("halted", halted, 1);
    check_eq("halt_valid", ir_valid, 0);
    check_eq("count4", fetch_count, 4);
    act = 0;
    for (int i = 0; i < 20; i++) begin
      rom_ack  = (i == 7);
      rom_data = 16'hBEEF;
      step();
      act += int'(rom_req) + int'(pc_inc) + int'(pc_load);
    end
    rom_ack  = 1'b0;
    rom_data = 16'h0;
    check_eq("halt_idle", act, 0);
    check_eq("halt_stays", halted, 1);
    check_eq("halt_ack_ignored", ir, 16'hF000);

    // Reset out of HALT, then reset during REQ with a late ack.
    do_reset();
    step();
    step();
    step();
    check_eq("pre_abort_req", rom_req, 1);
    rst = 1'b1;
    step();
    check_eq("abort_clr", {30'd0, pc_load, pc_inc}, 32'h3);
    check_eq("abort_req", rom_req, 0);
    rst = 1'b0;
    step();
    rom_ack  = 1'b1;
    rom_data = 16'hBEEF;
    step();
    rom_ack  = 1'b0;
    rom_data = 16'h0;
    check_eq("late_ack_ir", ir, 0);
    check_eq("late_ack_valid", ir_valid, 0);
    check_eq("late_ack_count", fetch_count, 0);
    step();
    check_eq("fresh_req", rom_req, 1);
    check_eq("fresh_addr", rom_addr, 16'h0000);

    // run=0 parks the sequencer in SETTLE.
    fetch_one(16'h1000, 0);
    step();
    run = 1'b0;
    step();
    step();
    act = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      act += int'(rom_req);
    end
    check_eq("stall_no_req", act, 0);
    run = 1'b1;
    step();
    check_eq("resume_req", rom_req, 1);
    check_eq("resume_addr", rom_addr, 16'h0001);

    // fetch_count wraps from 16'hFFFF to 0.
    ir_ready = 1'b0;
    fetch_one(16'h3000, 0);
    force dut.fetch_count = 16'hFFFF;
    step();
    release dut.fetch_count;
    ir_ready = 1'b1;
    step();
    check_eq("count_wrap", fetch_count, 0);
    check_eq("wrap_inc", {30'd0, pc_load, pc_inc}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch sequencer directly downstream of the program counter.
- Takes the PC's current address and reads the instruction ROM with a req/ack handshake.
- Latches the returned word into an instruction register (IR) and presents it to the decoder with a valid/ready handshake.
- Closes the loop by driving the PC's load/increment commands: sequential advance, absolute jump, halt, plus a PC clear after reset.

Parameters:
- PC_SETTLE, 2, cycles waited after any PC command before sampling pc_addr (min 1).
- OP_JMP, 4'hC, opcode value for an absolute jump.
- OP_HLT, 4'hF, opcode value for halt.

Ports:
- clk  in  1  system clock; all state updates on its rising edge. Only one clock exists.
- rst  in  1  synchronous, active-high reset.
- run  in  1  fetch enable; 0 stalls before the next ROM request.
- pc_addr  in  16  current PC output.
- pc_load  out  1  PC load command.
- pc_inc  out  1  PC increment command. pc_load=pc_inc=1 means clear PC to 0.
- jump_addr  out  16  load value for the PC (PC Ins_addr input).
- rom_req  out  1  ROM read request.
- rom_addr  out  16  ROM read address.
- rom_ack  in  1  ROM data valid, one cycle.
- rom_data  in  16  ROM read data.
- ir  out  16  instruction register.
- ir_valid  out  1  IR holds an instruction for the decoder.
- ir_ready  in  1  decoder accepts IR.
- halted  out  1  HLT has been retired.
- fetch_count  out  16  instructions accepted by the decoder; wraps 16'hFFFF -> 0.

Behaviour:
- Instruction format: [15:12] opcode, [11:0] imm12.
- FSM states: CLR, SETTLE, REQ, PRESENT, ADVANCE, HALT. All outputs are Moore decodes of the state plus registered data.
- rst=1 at an edge: state <= CLR; rom_addr, jump_addr, ir, fetch_count <= 0; settle counter <= 0.
- Output values while in reset/CLR: pc_load=1, pc_inc=1 (PC clear); rom_req=0, ir_valid=0, halted=0.
- CLR: lasts exactly one cycle after rst deasserts, then -> SETTLE.
- SETTLE: counter counts 0..PC_SETTLE-1; all commands are 0.
  - On the final count with run=1: -> REQ, and rom_addr <= pc_addr on that edge.
  - With run=0: stays on the final count until run=1.
- REQ: rom_req=1 and rom_addr stable until rom_ack.
  - rom_ack=1 at an edge: ir <= rom_data, -> PRESENT.
  - rom_ack in the first REQ cycle is valid, giving a 1-cycle ROM turnaround.
  - rom_ack in any state other than REQ is ignored.
- PRESENT: ir_valid=1 and ir is held stable.
  - ir_ready=1 at an edge: fetch_count += 1.
  - Next state on that edge: if opcode==OP_HLT -> HALT, else -> ADVANCE.
  - ir_ready high in the same cycle ir_valid first rises is an accept.
  - jump_addr <= {rom_addr[15:12], ir[11:0]} is registered on entry to ADVANCE.
- ADVANCE: exactly one cycle.
  - opcode==OP_JMP: pc_load=1, pc_inc=0.
  - Otherwise: pc_inc=1, pc_load=0.
  - Then -> SETTLE with the counter reset.
- HALT: halted=1, no commands, no requests. Leaves only via rst.
- pc_load and pc_inc are never 1 simultaneously outside CLR.
- rst mid-operation (any state, including REQ with an outstanding request): immediate return to CLR. Any later rom_ack for the abandoned request is ignored. fetch_count clears.
- Minimum instruction period, PC_SETTLE=2, 1-cycle ack, ready held: REQ 1 + PRESENT 1 + ADVANCE 1 + SETTLE 2 = 5 cycles.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_JMP, OP_HLT;
  - field bounds OPC_MSB=15, OPC_LSB=12, IMM_W=12;
  - fetch state enum;
  - DATA_W=16, ADDR_W=16.
- One natural sub-module: pc_settle_timer (load, run in; done out; width from PC_SETTLE).

Test Plan:
- Reset then release, ROM returns 16'h1000 with ack on the first REQ cycle, ir_ready=1 -> one CLR cycle with pc_load=pc_inc=1; rom_req rises 2 cycles later with rom_addr=0; ir=16'h1000; one pc_inc pulse; fetch_count=1.
- ROM word at 0x0000 = 16'hC0A5 -> after accept, one pc_load pulse with jump_addr=16'h00A5, pc_inc=0.
- ROM word 16'hF000 with ir_ready held low for 4 cycles -> ir_valid high and ir stable for 4 cycles; on accept, halted=1, then no rom_req/pc_inc/pc_load for 20 cycles.
- rom_ack delayed 5 cycles -> rom_req and rom_addr held constant for 5 cycles; no PC command issued during the wait.
- rst asserted while in REQ, then rom_ack pulsed one cycle after rst drops -> ack ignored; ir=0, fetch_count=0; CLR command issued; a fresh REQ follows.
- run=0 during SETTLE for 10 cycles -> no rom_req; rom_req rises the cycle after run=1. fetch_count wraps 16'hFFFF -> 0 when force-preloaded.
